// File: rtl/week2_onchip_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : week2_onchip_mem_arbiter                                         |
// | Purpose  : Two-master Avalon-MM arbiter in front of the single-port on-chip |
// |            RAM (1-cycle read latency). Define MEMARB_ROUND_ROBIN_EN for     |
// |            round-robin arbitration; otherwise m0 has fixed priority.        |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module week2_onchip_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [0:0] LAST0 = 1'b0;
    localparam logic [0:0] LAST1 = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              rd_own0_q, rd_own0_d;
    logic              rd_own1_q, rd_own1_d;
    logic              clken_q;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_wdata_q, last_wdata_d;

    logic arb_en;
    logic req0, req1;
    logic gnt0, gnt1;

    // Arbitration only opens once the RAM clock enable is up, and never in reset.
    assign arb_en = reset_n & clken_q;
    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;

`ifdef MEMARB_ROUND_ROBIN_EN
    assign gnt0 = arb_en & req0 & (~req1 | (state_q == LAST1));
    assign gnt1 = arb_en & req1 & (~req0 | (state_q == LAST0));
`else
    assign gnt0 = arb_en & req0;
    assign gnt1 = arb_en & req1 & ~req0;
`endif

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    always_comb begin
        mem_address    = last_addr_q;
        mem_writedata  = last_wdata_q;
        mem_byteenable = '0;
        mem_write      = 1'b0;
        mem_chipselect = 1'b0;
        if (gnt0) begin
            mem_address    = m0_address;
            mem_writedata  = m0_writedata;
            mem_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
            mem_write      = m0_write;
            mem_chipselect = 1'b1;
        end else if (gnt1) begin
            mem_address    = m1_address;
            mem_writedata  = m1_writedata;
            mem_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
            mem_write      = m1_write;
            mem_chipselect = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_addr_d  = last_addr_q;
        last_wdata_d = last_wdata_q;
        if (gnt0) begin
            state_d      = LAST0;
            last_addr_d  = m0_address;
            last_wdata_d = m0_writedata;
        end else if (gnt1) begin
            state_d      = LAST1;
            last_addr_d  = m1_address;
            last_wdata_d = m1_writedata;
        end
    end

    // A simultaneous read+write is a write, so it never claims a read return.
    assign rd_own0_d = gnt0 & m0_read & ~m0_write;
    assign rd_own1_d = gnt1 & m1_read & ~m1_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LAST1;
            rd_own0_q    <= 1'b0;
            rd_own1_q    <= 1'b0;
            clken_q      <= 1'b0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_own0_q    <= rd_own0_d;
            rd_own1_q    <= rd_own1_d;
            clken_q      <= 1'b1;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

    assign mem_clken        = clken_q;
    assign m0_readdatavalid = rd_own0_q;
    assign m1_readdatavalid = rd_own1_q;
    assign m0_readdata      = rd_own0_q ? mem_readdata : '0;
    assign m1_readdata      = rd_own1_q ? mem_readdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_week2_onchip_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_week2_onchip_mem_arbiter                                      |
// | Purpose  : Directed bench for week2_onchip_mem_arbiter with a behavioural   |
// |            1-cycle-latency RAM; honours MEMARB_ROUND_ROBIN_EN.              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_week2_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    week2_onchip_mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // Unwritten words read back as a recognisable address pattern.
    function automatic logic [31:0] pat(input logic [14:0] a);
        return 32'hA500_0000 | {17'b0, a};
    endfunction

    logic [31:0] ram [int];

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            logic [31:0] w;
            w = ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : pat(mem_address);
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) w[b*8 +: 8] = mem_writedata[b*8 +: 8];
                ram[int'(mem_address)] = w;
            end else begin
                mem_readdata <= w;
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m0_set(input logic rd, input logic wr, input logic [14:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    endtask

    task automatic m1_set(input logic rd, input logic wr, input logic [14:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    endtask

    task automatic idle();
        m0_set(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        m1_set(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
    endtask

    logic        g0, prev_g0, prev_g1;
    logic [31:0] prev_data;
    logic [14:0] k0, k1;
    int          cnt0, cnt1;

    initial begin
        reset_n = 1'b0;
        m0_set(1'b1, 1'b0, 15'h0001, 4'hF, 32'h0);
        m1_set(1'b1, 1'b0, 15'h0002, 4'hF, 32'h0);

        // Reset held with both masters requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk1("rst_wait0", m0_waitrequest, 1'b1);
            chk1("rst_wait1", m1_waitrequest, 1'b1);
            chk1("rst_cs", mem_chipselect, 1'b0);
            chk1("rst_wr", mem_write, 1'b0);
            chk1("rst_clken", mem_clken, 1'b0);
            chk1("rst_rdv0", m0_readdatavalid, 1'b0);
            chk1("rst_rdv1", m1_readdatavalid, 1'b0);
            chk32("rst_addr", {17'b0, mem_address}, 32'h0);
            chk32("rst_wdata", mem_writedata, 32'h0);
            chk32("rst_be", {28'b0, mem_byteenable}, 32'h0);
            chk32("rst_rd0", m0_readdata, 32'h0);
        end

        @(negedge clk); reset_n = 1'b1; #1;
        chk1("rel_clken0", mem_clken, 1'b0);
        chk1("rel_wait0", m0_waitrequest, 1'b1);
        chk1("rel_wait1", m1_waitrequest, 1'b1);
        chk1("rel_cs", mem_chipselect, 1'b0);

        @(negedge clk); #1;
        chk1("first_clken", mem_clken, 1'b1);
        chk1("first_wait0", m0_waitrequest, 1'b0);
        chk1("first_wait1", m1_waitrequest, 1'b1);
        chk1("first_cs", mem_chipselect, 1'b1);
        chk32("first_addr", {17'b0, mem_address}, 32'h1);

        @(negedge clk); idle(); #1;
        chk1("first_rdv0", m0_readdatavalid, 1'b1);
        chk32("first_rd0", m0_readdata, 32'hA500_0001);
        chk1("first_rdv1", m1_readdatavalid, 1'b0);
        chk1("idle_cs", mem_chipselect, 1'b0);
        chk32("idle_addr_hold", {17'b0, mem_address}, 32'h1);

        // Single write then read on m0
        @(negedge clk); m0_set(1'b0, 1'b1, 15'h0010, 4'hF, 32'hDEAD_BEEF); #1;
        chk1("w_wait0", m0_waitrequest, 1'b0);
        chk1("w_memwr", mem_write, 1'b1);
        chk32("w_addr", {17'b0, mem_address}, 32'h10);
        chk32("w_wdata", mem_writedata, 32'hDEAD_BEEF);
        chk32("w_be", {28'b0, mem_byteenable}, 32'hF);

        @(negedge clk); m0_set(1'b1, 1'b0, 15'h0010, 4'h0, 32'h0); #1;
        chk1("r_wait0", m0_waitrequest, 1'b0);
        chk1("r_memwr", mem_write, 1'b0);
        chk32("r_be_ones", {28'b0, mem_byteenable}, 32'hF);
        chk1("r_rdv0_early", m0_readdatavalid, 1'b0);

        @(negedge clk); idle(); #1;
        chk1("r_rdv0", m0_readdatavalid, 1'b1);
        chk32("r_rd0", m0_readdata, 32'hDEAD_BEEF);
        chk1("r_rdv1", m1_readdatavalid, 1'b0);
        chk32("r_rd1_gated", m1_readdata, 32'h0);
        @(negedge clk); #1;
        chk1("r_rdv0_once", m0_readdatavalid, 1'b0);
        chk32("r_rd0_gated", m0_readdata, 32'h0);

        // Byte-lane write at the top of the RAM
        @(negedge clk); m0_set(1'b0, 1'b1, 15'h7CFF, 4'hF, 32'h1122_3344);
        @(negedge clk); m0_set(1'b0, 1'b1, 15'h7CFF, 4'h1, 32'h0000_00AA); #1;
        chk32("bl_be", {28'b0, mem_byteenable}, 32'h1);
        @(negedge clk); m0_set(1'b1, 1'b0, 15'h7CFF, 4'h0, 32'h0);
        @(negedge clk); idle(); #1;
        chk1("bl_rdv0", m0_readdatavalid, 1'b1);
        chk32("bl_rd0", m0_readdata, 32'h1122_33AA);

        // Read+write together counts as a write: no read return
        @(negedge clk); m0_set(1'b1, 1'b1, 15'h0101, 4'hF, 32'h0000_0077); #1;
        chk1("rw_memwr", mem_write, 1'b1);
        @(negedge clk); idle(); #1;
        chk1("rw_no_rdv0", m0_readdatavalid, 1'b0);
        @(negedge clk); m0_set(1'b1, 1'b0, 15'h0101, 4'h0, 32'h0);
        @(negedge clk); idle(); #1;
        chk32("rw_rd0", m0_readdata, 32'h0000_0077);

        // Single m1 read leaves the last grant with m1
        @(negedge clk); m1_set(1'b1, 1'b0, 15'h0020, 4'h0, 32'h0); #1;
        chk1("m1_wait1", m1_waitrequest, 1'b0);
        @(negedge clk); idle(); #1;
        chk1("m1_rdv1", m1_readdatavalid, 1'b1);
        chk32("m1_rd1", m1_readdata, 32'hA500_0020);
        chk1("m1_rdv0", m0_readdatavalid, 1'b0);

        // Continuous contention for 8 cycles
        prev_g0 = 1'b0; prev_g1 = 1'b0; prev_data = 32'h0;
        k0 = 15'h0; k1 = 15'h0; cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 8) m0_set(1'b1, 1'b0, 15'h0200 + k0, 4'h0, 32'h0);
            else       m0_set(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
            m1_set(1'b1, 1'b0, 15'h0300 + k1, 4'h0, 32'h0);
            #1;
            if (c > 0) begin
                chk1("cont_rdv0", m0_readdatavalid, prev_g0);
                chk1("cont_rdv1", m1_readdatavalid, prev_g1);
                chk32("cont_data", prev_g0 ? m0_readdata : m1_readdata, prev_data);
                cnt0 += m0_readdatavalid ? 1 : 0;
                cnt1 += m1_readdatavalid ? 1 : 0;
            end
`ifdef MEMARB_ROUND_ROBIN_EN
            g0 = (c < 8) && ((c % 2) == 0);
`else
            g0 = (c < 8);
`endif
            chk1("cont_wait0", m0_waitrequest, (c < 8) ? ~g0 : 1'b1);
            chk1("cont_wait1", m1_waitrequest, g0);
            prev_g0 = g0;
            prev_g1 = ~g0;
            if (g0) begin prev_data = pat(15'h0200 + k0); k0++; end
            else    begin prev_data = pat(15'h0300 + k1); k1++; end
        end
`ifdef MEMARB_ROUND_ROBIN_EN
        chk32("cont_cnt0", cnt0, 32'd4);
        chk32("cont_cnt1", cnt1, 32'd4);
`else
        chk32("cont_cnt0", cnt0, 32'd8);
        chk32("cont_cnt1", cnt1, 32'd0);
`endif
        @(negedge clk); idle(); #1;
        chk1("cont_tail_rdv1", m1_readdatavalid, 1'b1);
        chk32("cont_tail_rd1", m1_readdata, prev_data);

        // m0 write and m1 read of the same word in the same cycle
        @(negedge clk);
        m0_set(1'b0, 1'b1, 15'h0100, 4'hF, 32'h0000_0005);
        m1_set(1'b1, 1'b0, 15'h0100, 4'h0, 32'h0);
        #1;
        chk1("rw2_wait0", m0_waitrequest, 1'b0);
        chk1("rw2_wait1", m1_waitrequest, 1'b1);
        chk1("rw2_memwr", mem_write, 1'b1);
        @(negedge clk); m0_set(1'b0, 1'b0, 15'h0, 4'h0, 32'h0); #1;
        chk1("rw2_wait1_b", m1_waitrequest, 1'b0);
        chk1("rw2_memwr_b", mem_write, 1'b0);
        @(negedge clk); idle(); #1;
        chk1("rw2_rdv1", m1_readdatavalid, 1'b1);
        chk32("rw2_rd1", m1_readdata, 32'h0000_0005);
        chk1("rw2_rdv0", m0_readdatavalid, 1'b0);

        // Reset in the cycle after an m1 read grant
        @(negedge clk); m1_set(1'b1, 1'b0, 15'h0030, 4'h0, 32'h0); #1;
        chk1("mr_wait1", m1_waitrequest, 1'b0);
        @(negedge clk); idle(); reset_n = 1'b0; #1;
        chk1("mr_rdv1_drop", m1_readdatavalid, 1'b0);
        chk32("mr_rd1_drop", m1_readdata, 32'h0);
        chk1("mr_clken", mem_clken, 1'b0);
        @(negedge clk); #1;
        chk1("mr_rdv1_hold", m1_readdatavalid, 1'b0);
        @(negedge clk); reset_n = 1'b1; #1;
        chk1("mr_rel_rdv1", m1_readdatavalid, 1'b0);
        chk1("mr_rel_rdv0", m0_readdatavalid, 1'b0);
        @(negedge clk); m1_set(1'b1, 1'b0, 15'h0030, 4'h0, 32'h0); #1;
        chk1("mr_post_rdv1", m1_readdatavalid, 1'b0);
        chk1("mr_post_wait1", m1_waitrequest, 1'b0);
        @(negedge clk); idle(); #1;
        chk1("mr_again_rdv1", m1_readdatavalid, 1'b1);
        chk32("mr_again_rd1", m1_readdata, 32'hA500_0030);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
